mem_stage: RTL and testbench

Memory-access stage of the CPU datapath, directly downstream of the ALU. It takes the execute-stage result (ALU output plus overflow flag) and the decoded memory operation. It issues the data-cache request (ALU output used as address), waits for the cache handshake, and delivers one registered write-back record per accepted operation. It also owns the LL/SC link register and flags overflow/misalignment exceptions.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/llsc_link.sv | 40 ++++
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, memory operations,
// exception codes and the memory-stage state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_SW   = 3'd2,
    MEM_LL   = 3'd3,
    MEM_SC   = 3'd4
  } memop_t;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_OVF  = 2'd1,
    EXC_ADEL = 2'd2,
    EXC_ADES = 2'd3
  } exc_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memstate_t;

endpackage

// File: rtl/llsc_link.sv
// LL/SC link register: remembers the address of the last completed LL and
// drops it on stores, matching snoop invalidates and reset.
`default_nettype none
module llsc_link
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  set,
  input  word_t set_addr,
  input  logic  clear,
  input  logic  snoop,
  input  word_t snoop_addr,
  input  word_t check_addr,
  output logic  link_match
);

  logic  link_valid;
  word_t link_addr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (clear) begin
      link_valid <= 1'b0;
    end else if (set) begin
      link_addr  <= set_addr;
      link_valid <= !(snoop && snoop_addr == set_addr);
    end else if (snoop && snoop_addr == link_addr) begin
      link_valid <= 1'b0;
    end
  end

  // A snoop landing in the same cycle as the check already kills the link.
  assign link_match = link_valid && (link_addr == check_addr) &&
                      !(snoop && snoop_addr == link_addr);

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
// Memory-access stage: issues data-cache requests, owns the LL/SC link and
// produces one registered write-back record (plus exception) per operation.
`default_nettype none
module mem_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ex_valid,
  output logic     ex_ready,
  input  memop_t   ex_memop,
  input  word_t    ex_aluout,
  input  logic     ex_overflow,
  input  logic     ex_trapovf,
  input  word_t    ex_store,
  input  regbits_t ex_wsel,
  input  logic     ex_wen,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  input  logic     dhit,
  input  word_t    dmemload,
  input  logic     ccinv,
  input  word_t    ccsnoopaddr,
  output logic     wb_valid,
  output logic     wb_wen,
  output regbits_t wb_wsel,
  output word_t    wb_data,
  output logic     exc_valid,
  output exc_t     exc_code
);

  memstate_t state, state_next;
  memop_t    op_q;
  logic      xfer, done, trap, is_mem, is_load, misaligned, sc_fail, go_access;
  logic      link_match;

  assign ex_ready   = (state == IDLE);
  assign xfer       = ex_valid && ex_ready;
  assign done       = (state == ACCESS) && dhit;
  assign trap       = ex_trapovf && ex_overflow;
  assign is_mem     = (ex_memop != MEM_NONE);
  assign is_load    = (ex_memop == MEM_LW) || (ex_memop == MEM_LL);
  assign misaligned = (ex_aluout[1:0] != 2'b00);
  assign sc_fail    = (ex_memop == MEM_SC) && !link_match;
  assign go_access  = xfer && !trap && is_mem && !misaligned && !sc_fail;

  llsc_link u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .set        (done && op_q == MEM_LL),
    .set_addr   (dmemaddr),
    .clear      (done && (op_q == MEM_SW || op_q == MEM_SC)),
    .snoop      (ccinv),
    .snoop_addr (ccsnoopaddr),
    .check_addr (ex_aluout),
    .link_match (link_match)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (go_access)  state_next = ACCESS;
    else if (done)  state_next = IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_q      <= MEM_NONE;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      wb_valid  <= 1'b0;
      wb_wen    <= 1'b0;
      wb_wsel   <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_code  <= EXC_NONE;
    end else begin
      wb_valid  <= 1'b0;
      wb_wen    <= 1'b0;
      exc_valid <= 1'b0;
      exc_code  <= EXC_NONE;
      if (xfer) begin
        wb_wsel <= ex_wsel;
        if (trap) begin
          wb_valid  <= 1'b1;
          wb_data   <= '0;
          exc_valid <= 1'b1;
          exc_code  <= EXC_OVF;
        end else if (is_mem && misaligned) begin
          wb_valid  <= 1'b1;
          wb_data   <= '0;
          exc_valid <= 1'b1;
          exc_code  <= is_load ? EXC_ADEL : EXC_ADES;
        end else if (!is_mem) begin
          wb_valid <= 1'b1;
          wb_wen   <= ex_wen;
          wb_data  <= ex_aluout;
        end else if (sc_fail) begin
          wb_valid <= 1'b1;
          wb_wen   <= 1'b1;
          wb_data  <= '0;
        end else begin
          op_q      <= ex_memop;
          dmemREN   <= is_load;
          dmemWEN   <= !is_load;
          dmemaddr  <= ex_aluout;
          dmemstore <= ex_store;
        end
      end else if (done) begin
        dmemREN  <= 1'b0;
        dmemWEN  <= 1'b0;
        wb_valid <= 1'b1;
        case (op_q)
          MEM_LW, MEM_LL: begin
            wb_wen  <= 1'b1;
            wb_data <= dmemload;
          end
          MEM_SC: begin
            wb_wen  <= 1'b1;
            wb_data <= 32'd1;
          end
          default: wb_data <= '0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level
// model of the stage (outcome per operation plus an LL/SC link variable).
`default_nettype none
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic     CLK = 1'b0;
  logic     nRST;
  logic     ex_valid, ex_ready;
  memop_t   ex_memop;
  word_t    ex_aluout, ex_store;
  logic     ex_overflow, ex_trapovf, ex_wen;
  regbits_t ex_wsel;
  logic     dmemREN, dmemWEN;
  word_t    dmemaddr, dmemstore;
  logic     dhit;
  word_t    dmemload;
  logic     ccinv;
  word_t    ccsnoopaddr;
  logic     wb_valid, wb_wen, exc_valid;
  regbits_t wb_wsel;
  word_t    wb_data;
  exc_t     exc_code;

  int vectors = 0;
  int miscompares = 0;

  // reference link state
  bit    m_lv = 0;
  word_t m_la = '0;

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_memop(ex_memop),
    .ex_aluout(ex_aluout), .ex_overflow(ex_overflow), .ex_trapovf(ex_trapovf),
    .ex_store(ex_store), .ex_wsel(ex_wsel), .ex_wen(ex_wen),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_code(exc_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete operation: transfer, optional cache access, write-back check.
  task automatic do_op(input memop_t op, input word_t addr, input bit ovf, input bit trp,
                       input regbits_t wsel, input bit wen, input word_t st,
                       input bit inv_x, input word_t inv_ax, input int dly,
                       input bit inv_h, input word_t inv_ah);
    word_t load;
    bit    access, e_exc, e_wen, chk_data;
    exc_t  e_code;
    word_t e_data;
    load = $urandom;
    check("ready_idle", ex_ready, 1);
    ex_valid = 1; ex_memop = op; ex_aluout = addr; ex_overflow = ovf; ex_trapovf = trp;
    ex_wsel = wsel; ex_wen = wen; ex_store = st; ccinv = inv_x; ccsnoopaddr = inv_ax;

    if (inv_x && m_lv && inv_ax == m_la) m_lv = 0;
    access = 0; e_exc = 0; e_code = EXC_NONE; e_wen = 0; e_data = '0; chk_data = 0;
    if (trp && ovf) begin
      e_exc = 1; e_code = EXC_OVF;
    end else if (op != MEM_NONE && addr[1:0] != 2'b00) begin
      e_exc = 1; e_code = (op == MEM_LW || op == MEM_LL) ? EXC_ADEL : EXC_ADES;
    end else if (op == MEM_NONE) begin
      e_wen = wen; e_data = addr; chk_data = wen;
    end else if (op == MEM_SC && !(m_lv && m_la == addr)) begin
      e_wen = 1; e_data = '0; chk_data = 1;
    end else begin
      access = 1;
    end

    tick();
    ex_valid = 0; ccinv = 0;

    if (access) begin
      for (int i = 0; i <= dly; i++) begin
        check("ready_busy", ex_ready, 0);
        check("ren_hold", dmemREN, (op == MEM_LW || op == MEM_LL));
        check("wen_hold", dmemWEN, (op == MEM_SW || op == MEM_SC));
        check("addr_hold", dmemaddr, addr);
        if (op == MEM_SW || op == MEM_SC) check("store_hold", dmemstore, st);
        check("wb_quiet", wb_valid, 0);
        if (i == dly) begin
          dhit = 1; dmemload = load; ccinv = inv_h; ccsnoopaddr = inv_ah;
        end
        tick();
      end
      dhit = 0; ccinv = 0;
      if (op == MEM_LL) begin
        m_la = addr; m_lv = !(inv_h && inv_ah == addr);
      end else if (op == MEM_SW || op == MEM_SC) begin
        m_lv = 0;
      end else if (inv_h && m_lv && inv_ah == m_la) begin
        m_lv = 0;
      end
      chk_data = (op != MEM_SW);
      e_wen    = (op != MEM_SW);
      e_data   = (op == MEM_SC) ? 32'd1 : load;
    end

    check("wb_valid", wb_valid, 1);
    check("wb_wen", wb_wen, e_wen);
    check("wb_wsel", wb_wsel, wsel);
    if (chk_data) check("wb_data", wb_data, e_data);
    check("exc_valid", exc_valid, e_exc);
    if (e_exc) check("exc_code", exc_code, e_code);
    check("ren_idle", dmemREN, 0);
    check("wen_idle", dmemWEN, 0);
    check("ready_after", ex_ready, 1);
  endtask

  word_t pool [6] = '{32'h200, 32'h204, 32'h100, 32'h102, 32'h101, 32'h10};

  initial begin
    nRST = 0; ex_valid = 0; ex_memop = MEM_NONE; ex_aluout = '0; ex_overflow = 0;
    ex_trapovf = 0; ex_store = '0; ex_wsel = '0; ex_wen = 0; dhit = 0; dmemload = '0;
    ccinv = 0; ccsnoopaddr = '0;
    #12;
    check("rst_ready", ex_ready, 1);
    check("rst_ren", dmemREN, 0);
    check("rst_wen", dmemWEN, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_excv", exc_valid, 0);
    check("rst_data", wb_data, 0);
    nRST = 1;
    tick();

    do_op(MEM_NONE, 32'h10, 0, 0, 5'd8, 1, '0, 0, '0, 0, 0, '0);
    do_op(MEM_LW, 32'h100, 0, 0, 5'd3, 1, '0, 0, '0, 3, 0, '0);
    do_op(MEM_NONE, 32'h8000_0000, 1, 1, 5'd4, 1, '0, 0, '0, 0, 0, '0);
    do_op(MEM_NONE, 32'h8000_0000, 1, 0, 5'd4, 1, '0, 0, '0, 0, 0, '0);
    do_op(MEM_LW, 32'h102, 0, 0, 5'd5, 1, '0, 0, '0, 0, 0, '0);
    do_op(MEM_SW, 32'h101, 0, 0, 5'd0, 0, 32'h55, 0, '0, 0, 0, '0);
    do_op(MEM_LL, 32'h200, 0, 0, 5'd6, 1, '0, 0, '0, 1, 0, '0);
    do_op(MEM_SC, 32'h200, 0, 0, 5'd7, 1, 32'hAA, 0, '0, 2, 0, '0);
    do_op(MEM_LL, 32'h200, 0, 0, 5'd6, 1, '0, 0, '0, 0, 0, '0);
    do_op(MEM_NONE, 32'h0, 0, 0, 5'd1, 0, '0, 1, 32'h200, 0, 0, '0);
    do_op(MEM_SC, 32'h200, 0, 0, 5'd7, 1, 32'hAA, 0, '0, 0, 0, '0);
    do_op(MEM_LL, 32'h200, 0, 0, 5'd6, 1, '0, 0, '0, 0, 0, '0);
    do_op(MEM_SC, 32'h204, 0, 0, 5'd7, 1, 32'hAA, 0, '0, 0, 0, '0);
    do_op(MEM_LL, 32'h200, 0, 0, 5'd6, 1, '0, 0, '0, 0, 1, 32'h200);
    do_op(MEM_SC, 32'h200, 0, 0, 5'd7, 1, 32'hAA, 0, '0, 0, 0, '0);
    do_op(MEM_LL, 32'h200, 0, 0, 5'd6, 1, '0, 0, '0, 0, 0, '0);
    do_op(MEM_SC, 32'h200, 0, 0, 5'd7, 1, 32'hAA, 1, 32'h200, 0, 0, '0);

    for (int n = 0; n < 300; n++) begin
      memop_t op;
      word_t  a;
      bit     w;
      op = memop_t'($urandom_range(0, 4));
      a  = ($urandom_range(0, 7) == 0) ? word_t'($urandom) : pool[$urandom_range(0, 5)];
      w  = (op == MEM_NONE) ? bit'($urandom_range(0, 1)) : (op != MEM_SW);
      do_op(op, a, bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            regbits_t'($urandom), w, word_t'($urandom),
            ($urandom_range(0, 4) == 0), pool[$urandom_range(0, 5)],
            $urandom_range(0, 3),
            ($urandom_range(0, 4) == 0), pool[$urandom_range(0, 5)]);
    end

    // Asynchronous reset in the middle of an access.
    do_op(MEM_LL, 32'h200, 0, 0, 5'd6, 1, '0, 0, '0, 0, 0, '0);
    ex_valid = 1; ex_memop = MEM_LW; ex_aluout = 32'h100; ex_overflow = 0; ex_trapovf = 0;
    tick();
    ex_valid = 0;
    check("pre_rst_ren", dmemREN, 1);
    #1 nRST = 0;
    #1;
    check("arst_ren", dmemREN, 0);
    check("arst_ready", ex_ready, 1);
    check("arst_wbv", wb_valid, 0);
    m_lv = 0;
    #1 nRST = 1;
    tick();
    do_op(MEM_SC, 32'h200, 0, 0, 5'd7, 1, 32'hAA, 0, '0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
